// File: rtl/rmst_pkg.sv
// Shared types and constants for the input-feature-map read master controller.
package rmst_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StConfig = 3'b001,
    StWait   = 3'b010,
    StTrans  = 3'b011,
    StDone   = 3'b111
  } state_e;

  localparam int unsigned ByteShift = 2;

  // Valid extent of a tile along one axis; zero when the origin lies past the edge.
  function automatic int unsigned clip_len(input int unsigned base, input int unsigned lim,
                                           input int unsigned tile);
    if (base >= lim) return 0;
    return ((lim - base) < tile) ? (lim - base) : tile;
  endfunction

endpackage

// File: rtl/in_fm_ld_counter.sv
// 2-D nested counter: cnt0 is the inner index, cnt1 the outer; done pulses on the final increment.
module in_fm_ld_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] n0_max,
  input  logic [CW-1:0] n1_max,
  input  logic          ena,
  input  logic          syn_rst,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic          done
);

  logic [CW-1:0] cnt0_q, cnt1_q;
  logic          wrap0;

  assign wrap0 = (cnt0_q == n0_max);
  assign done  = ena && wrap0 && (cnt1_q == n1_max);
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (syn_rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (ena) begin
      if (wrap0) begin
        cnt0_q <= '0;
        cnt1_q <= (cnt1_q == n1_max) ? '0 : cnt1_q + CW'(1);
      end else begin
        cnt0_q <= cnt0_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rmst_in_fm_ctrl.sv
// Input-feature-map tile load controller: one Avalon read burst per (channel, row) of a tile.
// Optional RMST_COL_CLIP_EN clips the burst length at the right edge of the feature map.
module rmst_in_fm_ctrl
  import rmst_pkg::*;
#(
  parameter int unsigned CW         = 16,
  parameter int unsigned XAW        = 32,
  parameter int unsigned N          = 32,
  parameter int unsigned R          = 64,
  parameter int unsigned C          = 32,
  parameter int unsigned Tn         = 16,
  parameter int unsigned Tr         = 64,
  parameter int unsigned Tc         = 16,
  parameter int unsigned IN_FM_BASE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_start,
  output logic           load_done,
  input  logic [CW-1:0]  tile_base_n,
  input  logic [CW-1:0]  tile_base_row,
  input  logic [CW-1:0]  tile_base_col,
  output logic [XAW-1:0] param_raddr,
  output logic [CW-1:0]  param_iolen,
  output logic           load_trans_start,
  input  logic           load_trans_done,
  input  logic           load_fifo_almost_full
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] base_n_q, base_row_q, base_col_q;
  logic [CW-1:0] vn_q, vr_q, vc_q;
  logic [CW-1:0] vn_new, vr_new, vc_new;
  logic          zero_new, accept, cnt_ena, cnt_done;
  logic [CW-1:0] tn, tr;
  logic          trans_start_d, done_d;
  logic [XAW-1:0] word_addr;

  assign vn_new = CW'(clip_len(32'(tile_base_n), N, Tn));
  assign vr_new = CW'(clip_len(32'(tile_base_row), R, Tr));
`ifdef RMST_COL_CLIP_EN
  assign vc_new = CW'(clip_len(32'(tile_base_col), C, Tc));
`else
  assign vc_new = CW'(Tc);
`endif
  assign zero_new = (vn_new == '0) || (vr_new == '0) || (vc_new == '0);
  assign accept   = (state_q == StIdle) && load_start;

  in_fm_ld_counter #(
    .CW(CW)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .n0_max (vr_q - CW'(1)),
    .n1_max (vn_q - CW'(1)),
    .ena    (cnt_ena),
    .syn_rst(accept),
    .cnt0   (tr),
    .cnt1   (tn),
    .done   (cnt_done)
  );

  // Word address wraps modulo 2^XAW by construction.
  assign word_addr = XAW'(IN_FM_BASE)
                   + (XAW'(base_n_q) + XAW'(tn)) * XAW'(R * C)
                   + (XAW'(base_row_q) + XAW'(tr)) * XAW'(C)
                   + XAW'(base_col_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_ena = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          last_d = zero_new;
          if (zero_new)                   state_d = StDone;
          else if (load_fifo_almost_full) state_d = StWait;
          else                            state_d = StConfig;
        end
      end
      StWait: begin
        if (!load_fifo_almost_full) state_d = StConfig;
      end
      StConfig: begin
        cnt_ena = 1'b1;
        if (cnt_done) last_d = 1'b1;
        state_d = StTrans;
      end
      StTrans: begin
        if (load_trans_done) state_d = StDone;
      end
      StDone: begin
        if (last_q) begin
          last_d  = 1'b0;
          state_d = StIdle;
        end else if (load_fifo_almost_full) begin
          state_d = StWait;
        end else begin
          state_d = StConfig;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign trans_start_d = (state_q == StConfig);
  assign done_d        = (state_q == StDone) && last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_n_q         <= '0;
      base_row_q       <= '0;
      base_col_q       <= '0;
      vn_q             <= '0;
      vr_q             <= '0;
      vc_q             <= '0;
      param_raddr      <= XAW'(IN_FM_BASE) << ByteShift;
      param_iolen      <= '0;
      load_trans_start <= 1'b0;
      load_done        <= 1'b0;
    end else begin
      load_trans_start <= trans_start_d;
      load_done        <= done_d;
      if (accept) begin
        base_n_q   <= tile_base_n;
        base_row_q <= tile_base_row;
        base_col_q <= tile_base_col;
        vn_q       <= vn_new;
        vr_q       <= vr_new;
        vc_q       <= vc_new;
      end else if (done_d) begin
        vn_q <= '0;
        vr_q <= '0;
        vc_q <= '0;
      end
      if (state_q == StConfig) begin
        param_raddr <= word_addr << ByteShift;
        param_iolen <= vc_q;
      end
    end
  end

endmodule

// File: tb/tb_rmst_in_fm_ctrl.sv
// Directed bench: a default-sized instance for the full-tile run and a small instance for edges.
module tb_rmst_in_fm_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Default-parameter instance
  logic        b_rst = 1'b1, b_start = 1'b0, b_ld, b_ts, b_done_auto = 1'b0;
  logic [15:0] b_bn = '0, b_br = '0, b_bc = '0, b_iolen;
  logic [31:0] b_raddr;
  int          b_ts_cnt = 0, b_done_cnt = 0, b_len_bad = 0, b_pend = 0;
  logic [31:0] b_addr0 = '0, b_addr1 = '0;

  rmst_in_fm_ctrl u_big (
    .clk                  (clk),
    .rst                  (b_rst),
    .load_start           (b_start),
    .load_done            (b_ld),
    .tile_base_n          (b_bn),
    .tile_base_row        (b_br),
    .tile_base_col        (b_bc),
    .param_raddr          (b_raddr),
    .param_iolen          (b_iolen),
    .load_trans_start     (b_ts),
    .load_trans_done      (b_done_auto),
    .load_fifo_almost_full(1'b0)
  );

  always @(negedge clk) begin
    if (b_ts) begin
      if (b_ts_cnt == 0) b_addr0 = b_raddr;
      if (b_ts_cnt == 1) b_addr1 = b_raddr;
      if (b_iolen != 16'd16) b_len_bad++;
      b_ts_cnt++;
    end
    if (b_ld) b_done_cnt++;
    b_done_auto = 1'b0;
    if (b_rst) b_pend = 0;
    else if (b_pend > 0) begin
      b_pend--;
      if (b_pend == 0) b_done_auto = 1'b1;
    end
    if (b_ts && !b_rst) b_pend = 2;
  end

  // Small instance: N=4 R=6 C=8 Tn=2 Tr=4 Tc=4
  logic        s_rst = 1'b1, s_start = 1'b0, s_ld, s_ts, s_af = 1'b0;
  logic        s_done_auto = 1'b0, s_done_man = 1'b0, s_trans_done;
  logic [15:0] s_bn = '0, s_br = '0, s_bc = '0, s_iolen;
  logic [31:0] s_raddr;
  int          s_done_cnt = 0, s_pend = 0;
  logic [31:0] s_addr_q[$];
  logic [15:0] s_len_q[$];

  assign s_trans_done = s_done_auto | s_done_man;

  rmst_in_fm_ctrl #(
    .N (4),
    .R (6),
    .C (8),
    .Tn(2),
    .Tr(4),
    .Tc(4)
  ) u_dut (
    .clk                  (clk),
    .rst                  (s_rst),
    .load_start           (s_start),
    .load_done            (s_ld),
    .tile_base_n          (s_bn),
    .tile_base_row        (s_br),
    .tile_base_col        (s_bc),
    .param_raddr          (s_raddr),
    .param_iolen          (s_iolen),
    .load_trans_start     (s_ts),
    .load_trans_done      (s_trans_done),
    .load_fifo_almost_full(s_af)
  );

  always @(negedge clk) begin
    if (s_ts) begin
      s_addr_q.push_back(s_raddr);
      s_len_q.push_back(s_iolen);
    end
    if (s_ld) s_done_cnt++;
    s_done_auto = 1'b0;
    if (s_rst) s_pend = 0;
    else if (s_pend > 0) begin
      s_pend--;
      if (s_pend == 0) s_done_auto = 1'b1;
    end
    if (s_ts && !s_rst) s_pend = 2;
  end

  // Call at a falling edge; the start pulse covers exactly one rising edge.
  task automatic pulse_start(input logic [15:0] bn, input logic [15:0] br, input logic [15:0] bc);
    s_bn = bn;
    s_br = br;
    s_bc = bc;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic wait_s_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (s_done_cnt >= target) break;
    end
    check(tag, s_done_cnt, target);
  endtask

  task automatic clear_log();
    s_addr_q.delete();
    s_len_q.delete();
  endtask

  initial begin
    int done_before;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", s_ld, 0);
    check("rst_ts", s_ts, 0);
    check("rst_raddr", s_raddr, 0);
    check("rst_iolen", s_iolen, 0);
    check("rst_big_raddr", b_raddr, 0);
    b_rst = 1'b0;
    s_rst = 1'b0;

    // Full default tile: 16 channels x 64 rows
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1;
      if (b_done_cnt >= 1) break;
    end
    repeat (5) @(negedge clk);
    #1;
    check("big_bursts", b_ts_cnt, 1024);
    check("big_addr0", b_addr0, 0);
    check("big_addr1", b_addr1, 128);
    check("big_len_bad", b_len_bad, 0);
    check("big_done", b_done_cnt, 1);

    // Edge tile with start latency
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    pulse_start(16'd2, 16'd4, 16'd4);
    check("lat_ts_t1", s_ts, 0);
    @(negedge clk);
    check("lat_ts_t2", s_ts, 1);
    check("lat_raddr", s_raddr, 528);
    check("lat_iolen", s_iolen, 4);
    wait_s_done(1, 200, "edge_done");
    check("edge_bursts", s_addr_q.size(), 4);
    check("edge_a1", s_addr_q[1], 560);
    check("edge_a2", s_addr_q[2], 720);
    check("edge_a3", s_addr_q[3], 752);
    check("edge_len3", s_len_q[3], 4);

    // FIFO almost full for 10 cycles from the start cycle
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    s_af = 1'b1;
    pulse_start(16'd0, 16'd0, 16'd0);
    repeat (9) @(negedge clk);
    #1;
    check("af_no_ts", s_addr_q.size(), 0);
    s_af = 1'b0;
    @(negedge clk);
    check("af_ts_t1", s_ts, 0);
    @(negedge clk);
    check("af_ts_t2", s_ts, 1);
    wait_s_done(1, 300, "af_done");
    check("af_bursts", s_addr_q.size(), 8);
    check("af_a1", s_addr_q[1], 32);
    check("af_a4", s_addr_q[4], 192);

    // Reset during the second burst
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    pulse_start(16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (s_addr_q.size() >= 2) break;
    end
    check("rst_mid_seen2", s_addr_q.size(), 2);
    s_rst = 1'b1;
    #1;
    check("rst_mid_ts", s_ts, 0);
    check("rst_mid_raddr", s_raddr, 0);
    check("rst_mid_iolen", s_iolen, 0);
    check("rst_mid_ld", s_ld, 0);
    @(negedge clk);
    s_rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("rst_mid_no_done", s_done_cnt, 0);
    check("rst_mid_no_ts", s_addr_q.size(), 2);
    clear_log();
    @(negedge clk);
    pulse_start(16'd2, 16'd4, 16'd4);
    wait_s_done(1, 200, "post_rst_done");
    check("post_rst_bursts", s_addr_q.size(), 4);
    check("post_rst_a3", s_addr_q[3], 752);

    // Stray burst-done in IDLE, then a second start during TRANS
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    s_done_man = 1'b1;
    @(negedge clk);
    s_done_man = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("stray_no_ts", s_addr_q.size(), 0);
    check("stray_no_done", s_done_cnt, 0);
    @(negedge clk);
    pulse_start(16'd2, 16'd4, 16'd4);
    @(negedge clk);
    pulse_start(16'd0, 16'd0, 16'd0);
    wait_s_done(1, 200, "dup_done");
    repeat (10) @(negedge clk);
    #1;
    check("dup_bursts", s_addr_q.size(), 4);
    check("dup_a0", s_addr_q[0], 528);
    check("dup_a3", s_addr_q[3], 752);
    check("dup_one_done", s_done_cnt, 1);

    // Zero channels: done without bursts, and back-to-back start accepted
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    pulse_start(16'd4, 16'd0, 16'd0);
    check("zero_ld_t1", s_ld, 0);
    @(negedge clk);
    check("zero_ld_t2", s_ld, 1);
    pulse_start(16'd2, 16'd4, 16'd4);
    check("b2b_ld_t3", s_ld, 0);
    check("b2b_ts_t3", s_ts, 0);
    check("zero_no_ts", s_addr_q.size(), 0);
    @(negedge clk);
    check("b2b_ts_t4", s_ts, 1);
    check("b2b_raddr", s_raddr, 528);
    wait_s_done(2, 200, "b2b_done");
    check("b2b_bursts", s_addr_q.size(), 4);

`ifdef RMST_COL_CLIP_EN
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    pulse_start(16'd0, 16'd0, 16'd6);
    wait_s_done(1, 300, "clip_done");
    check("clip_bursts", s_addr_q.size(), 8);
    check("clip_len0", s_len_q[0], 2);
    check("clip_a0", s_addr_q[0], 24);
    clear_log();
    s_done_cnt = 0;
    @(negedge clk);
    pulse_start(16'd0, 16'd0, 16'd8);
    wait_s_done(1, 20, "clip_zero_done");
    check("clip_zero_bursts", s_addr_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rmst_in_fm_ctrl.md
# rmst_in_fm_ctrl

Controls the Avalon read master that fetches one input-feature-map tile from DDR into the on-chip load FIFO. It is the read-side counterpart of the output-feature-map store controller. The tile scheduler issues a one-cycle `load_start` with tile bases. The block then issues one read burst per (channel, row) of the tile, throttles on FIFO space, and pulses `load_done` after the last burst completes.

## Interface
- `CW`, 16: width of tile-base, length and counter fields
- `XAW`, 32: external byte-address width
- `N`, 32: input channels
- `R`, 64: input rows
- `C`, 32: input columns
- `Tn`, 16: tile channels
- `Tr`, 64: tile rows
- `Tc`, 16: tile columns (words per burst)
- `IN_FM_BASE`, 0: word base address of the input feature map in DDR

Ports:
- `clk` input 1: single clock
- `rst` input 1: asynchronous, active-high reset
- `load_start` input 1: one-cycle pulse; tile bases are valid in this cycle
- `load_done` output 1: one-cycle pulse when the whole tile has been read
- `tile_base_n`, `tile_base_row`, `tile_base_col` input CW each: tile origin
- `param_raddr` output XAW: burst byte address (word address << 2)
- `param_iolen` output CW: burst length in words
- `load_trans_start` output 1: one-cycle pulse that starts a read burst
- `load_trans_done` input 1: one-cycle pulse when the burst has completed
- `load_fifo_almost_full` input 1: high when the FIFO cannot accept Tc more words

## Operation
- Lengths are latched on `load_start`:
  - `vn = min(Tn, N-base_n)`
  - `vr = min(Tr, R-base_row)`
  - `vc = Tc`
- Lengths are cleared on `load_done`.
- The 2-D counter has `tr` as the inner index (0..vr-1) and `tn` as the outer index (0..vn-1). Total bursts per tile = `vn*vr`.
- Burst word address = `IN_FM_BASE + (base_n+tn)*R*C + (base_row+tr)*C + base_col`. Compute it at XAW width; it wraps modulo 2^XAW.
- FSM states: IDLE, WAIT, CONFIG, TRANS, DONE.
- Transitions out of IDLE:
  - `load_start` with `vn` or `vr` = 0 goes to DONE with the last flag set. No burst is issued.
  - `load_start` with almost_full goes to WAIT.
  - `load_start` otherwise goes to CONFIG.
- WAIT goes to CONFIG when `!load_fifo_almost_full`.
- CONFIG always goes to TRANS. In CONFIG the block:
  - registers `param_raddr` and `param_iolen` from the current counters;
  - advances the counter;
  - sets the last flag if this was the final (tn, tr).
- TRANS goes to DONE on `load_trans_done`. A `load_trans_done` seen in any other state is ignored.
- Transitions out of DONE:
  - last flag set goes to IDLE and pulses `load_done`;
  - else almost_full goes to WAIT;
  - else goes to CONFIG.
- `load_start` is ignored in any state other than IDLE.

## Timing
- Reset values: `load_done`=0, `load_trans_start`=0, `param_raddr`=`IN_FM_BASE`<<2, `param_iolen`=0, FSM=IDLE, counters=0, last flag=0.
- From `load_start` at cycle t (FIFO not full):
  - CONFIG at t+1;
  - `load_trans_start`, `param_raddr` and `param_iolen` valid at t+2.
- `param_raddr` and `param_iolen` hold stable from the `load_trans_start` cycle until the next CONFIG.
- Each burst after the first costs at least 3 cycles: DONE, CONFIG, then `load_trans_start`.
- `load_done` is registered and rises in the cycle after DONE with the last flag set. The FSM is already IDLE in that cycle, so a `load_start` in that same cycle is accepted.
- `load_fifo_almost_full` is sampled only in IDLE, WAIT and DONE. A change during TRANS has no effect on the burst in flight.
- Reset asserted mid-tile returns everything to reset values immediately. The outstanding burst is abandoned and no `load_done` is produced.

## Configuration
- `RMST_COL_CLIP_EN` defined: `vc = min(Tc, C-base_col)`. A `vc` of 0 is treated like `vn`/`vr` = 0.
- `RMST_COL_CLIP_EN` undefined: `vc = Tc` always. The scheduler guarantees `base_col+Tc <= C`.

## Structure
- Package `rmst_pkg` holds:
  - the FSM state typedef: IDLE=3'b000, CONFIG=3'b001, WAIT=3'b010, TRANS=3'b011, DONE=3'b111;
  - the byte-shift constant (2).
- Sub-module `in_fm_ld_counter`, a 2-D nested counter:
  - inputs: `n0_max`, `n1_max`, `ena`, `syn_rst`;
  - outputs: `cnt0`, `cnt1`, and a `done` pulse on the final increment;
  - same `clk`/`rst` as the parent.

## Test plan
All scenarios except the first use N=4, R=6, C=8, Tn=2, Tr=4, Tc=4.
- Defaults, bases 0/0/0, FIFO never full:
  - exactly 1024 `load_trans_start` pulses;
  - first `param_raddr`=0, second 128, all `param_iolen`=16;
  - one `load_done` pulse.
- Bases n=2, row=4, col=4 (`vn`=2, `vr`=2):
  - 4 bursts at byte addresses 528, 560, 720, 752, each with `param_iolen`=4.
- `load_fifo_almost_full` held high for 10 cycles after `load_start`:
  - no `load_trans_start` until 2 cycles after deassertion.
- `rst` pulsed during the 2nd burst's TRANS:
  - all outputs return to reset values, no `load_done`;
  - a following tile runs normally.
- A second `load_start` during TRANS, and `load_trans_done` in IDLE, are both ignored.
- With `RMST_COL_CLIP_EN` defined, base_col=6:
  - `param_iolen`=2;
  - with base_n=4 (so `vn`=0), `load_done` pulses with zero bursts.
